audio_pwm_out: RTL
==================

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the sample buffer depth (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 The block SHALL have port d_in  input  8  signed two's-complement audio sample from the high-pass (DC-block) stage.
REQ-005 The block SHALL have port d_valid  input  1  d_in qualifier; one sample per high cycle.
REQ-006 The block SHALL have port clr_flags  input  1  synchronous clear of the sticky flags.
REQ-007 The block SHALL have port pwm_out  output  1  registered PWM audio bit.
REQ-008 The block SHALL have port sample_tick  output  1  one-cycle pulse when a new duty value is loaded.
REQ-009 The block SHALL have port fifo_level  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-010 The block SHALL have port overflow  output  1  sticky flag: a sample was dropped.
REQ-011 The block SHALL have port underrun  output  1  sticky flag: a period ended with the FIFO empty.

Function
REQ-012 The block SHALL use an 8-bit period counter cnt that increments every cycle and wraps from 255 to 0, giving a 256-cycle PWM period.
REQ-013 The block SHALL form the duty value from a sample by inverting its MSB: -128 maps to 0, 0 maps to 128, +127 maps to 255.
REQ-014 Each cycle, the block SHALL register pwm_out as (cnt < duty_reg), so pwm_out is high for exactly duty_reg cycles per period with a one-cycle latency (duty 0 gives always low; duty 255 gives 255 of 256 cycles high).
REQ-015 A push SHALL occur when d_valid=1 and the FIFO is not full; order is first-in, first-out.
REQ-016 When d_valid=1 and the FIFO is full with no pop in the same cycle, the block SHALL discard the sample and set overflow.
REQ-017 When the FIFO is full and a pop occurs in the same cycle, a d_valid sample SHALL be accepted, leaving fifo_level unchanged.
REQ-018 On the cnt==255 cycle with the FIFO non-empty, the block SHALL pop the head, load its mapped duty into duty_reg (effective from cnt==0), and pulse sample_tick for that cycle.
REQ-019 On the cnt==255 cycle with the FIFO empty, the block SHALL hold duty_reg, set underrun, and leave sample_tick low.
REQ-020 A push into an empty FIFO on the cnt==255 cycle SHALL NOT be popped in that cycle; underrun SHALL be set, and the sample SHALL remain stored for the next period.
REQ-021 fifo_level SHALL update one cycle after a push or pop: +1 on push only, -1 on pop only, unchanged on both.
REQ-022 clr_flags=1 SHALL clear overflow and underrun on the next edge, except that a flag-setting event in the same cycle wins and leaves that flag set.
REQ-023 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from an occupancy count, not pointer equality alone.

Reset
REQ-024 While rst_n=0 the block SHALL hold cnt=0, duty_reg=128, pwm_out=0, sample_tick=0, fifo_level=0, overflow=0, underrun=0, and an empty FIFO, regardless of clk.
REQ-025 Assertion of rst_n mid-period or with FIFO data SHALL discard all buffered samples; the first edge after release SHALL evaluate cnt=0 with duty 128.
REQ-026 After reset release with no input, the block SHALL output a 50% square wave (128 high, 128 low) and set underrun at the first cnt==255.

Verification
REQ-027 Release reset, no d_valid -> pwm_out is high for 128 cycles then low for 128, underrun=1 after cycle 256, and sample_tick never pulses.
REQ-028 Push samples -128, 0, 127 at cnt=10 -> successive periods show high widths of 0, 128 and 255, with sample_tick at each cnt==255, then fifo_level=0 and underrun set at the following wrap.
REQ-029 Push 5 samples back-to-back with FIFO_DEPTH=4, away from cnt==255 -> the first 4 are stored, the 5th is dropped, overflow=1, and fifo_level=4.
REQ-030 With the FIFO full, push a sample on the cnt==255 cycle -> the sample is accepted, fifo_level stays 4, sample_tick=1, and overflow stays 0.
REQ-031 With the FIFO empty, push 0x40 on the cnt==255 cycle -> underrun=1, duty is held, and the next period has a high width of 192 (0x40 mapped to 0xC0).
REQ-032 Assert rst_n low mid-period with fifo_level=3, then pulse clr_flags while a drop occurs -> reset restores all REQ-024 values, and the overflow flag remains set after the simultaneous clear.

Source files
------------

// File: rtl/audio_pwm_out.sv
// Sample FIFO feeding a 256-cycle PWM DAC. pwm_out lags cnt by one cycle; a new duty is loaded at cnt==255.
// No backpressure: samples arriving at a full FIFO are dropped (overflow); empty at wrap holds duty (underrun).

module audio_pwm_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic [4:0]   level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Depth is a power of two, so pointers wrap naturally; occupancy lives in level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
endmodule

module audio_pwm_out #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d_in,
  input  logic       d_valid,
  input  logic       clr_flags,
  output logic       pwm_out,
  output logic       sample_tick,
  output logic [4:0] fifo_level,
  output logic       overflow,
  output logic       underrun
);
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  logic [7:0] cnt;
  logic [7:0] duty_reg;
  logic [7:0] head_dat;
  logic       period_end;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop_vld;
  logic       push_vld;
  logic       drop;
  logic       starve;

  assign period_end = (cnt == 8'hFF);
  assign fifo_empty = (fifo_level == 5'd0);
  assign fifo_full  = (fifo_level == DEPTH_L);
  // Pop decision uses pre-push occupancy, so a sample arriving at the wrap waits a period.
  assign pop_vld    = period_end && !fifo_empty;
  assign push_vld   = d_valid && (!fifo_full || pop_vld);
  assign drop       = d_valid && fifo_full && !pop_vld;
  assign starve     = period_end && fifo_empty;

  audio_pwm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (d_in),
    .pop_vld  (pop_vld),
    .pop_dat  (head_dat),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 8'd0;
      duty_reg    <= 8'd128;
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
      overflow    <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt + 8'd1;
      pwm_out     <= (cnt < duty_reg);
      sample_tick <= pop_vld;
      // Flipping the sign bit turns two's complement into offset-binary duty.
      if (pop_vld) duty_reg <= {~head_dat[7], head_dat[6:0]};
      overflow    <= drop   || (overflow && !clr_flags);
      underrun    <= starve || (underrun && !clr_flags);
    end
  end
endmodule
